// File: rtl/xadc_telem_pkg.sv
// Shared types and helpers for the XADC telemetry packer.
// Latency: n/a (types, constants and a combinational byte mux only).
// Backpressure: n/a.
package xadc_telem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int FRAME_LEN_BASE = 20;
  localparam int FRAME_LEN_CSUM = 21;
  localparam int BYTE_IDX_W     = 5;
  localparam int NUM_WORDS      = 8;

  // words[0] = TEMP ... words[7] = AUX3, in frame order
  typedef struct packed {
    logic [NUM_WORDS-1:0][15:0] words;
    logic [7:0]                 alm;
    logic                       ot;
  } snap_t;

  // Maps a frame byte index onto the snapshot; indices past the data bytes return 0
  function automatic logic [7:0] frame_byte(
    input logic [BYTE_IDX_W-1:0] idx,
    input snap_t                 snap,
    input logic [7:0]            seq,
    input logic [7:0]            sync
  );
    logic [2:0]  wsel;
    logic [15:0] w;
    logic [7:0]  b;
    wsel = 3'((idx - BYTE_IDX_W'(4)) >> 1);
    w    = snap.words[wsel];
    case (idx)
      5'd0:    b = sync;
      5'd1:    b = seq;
      5'd2:    b = snap.alm;
      5'd3:    b = {7'b0, snap.ot};
      default: begin
        if (idx < BYTE_IDX_W'(FRAME_LEN_BASE)) b = idx[0] ? w[7:0] : w[15:8];
        else                                   b = 8'h00;
      end
    endcase
    return b;
  endfunction

endpackage

// File: rtl/xadc_telemetry_packer.sv
// Snapshots XADC measurements on a (decimated) EOS edge and streams them as a framed byte sequence.
// Latency: trigger at edge k -> TX_VALID with SYNC_MARK after edge k; 20 bytes/frame (21 with XADC_TELEM_CHECKSUM_EN).
// Backpressure: TX_DATA held while TX_VALID && !TX_READY; triggers arriving while busy are dropped and flagged.
module xadc_telemetry_packer
  import xadc_telem_pkg::*;
#(
  parameter logic [7:0] SYNC_MARK  = 8'hA5,
  parameter int         DECIMATION = 1
) (
  input  logic        DCLK,
  input  logic        RESET,
  input  logic [15:0] MEAS_TEMP,
  input  logic [15:0] MEAS_VCCINT,
  input  logic [15:0] MEAS_VCCAUX,
  input  logic [15:0] MEAS_VCCBRAM,
  input  logic [15:0] MEAS_AUX0,
  input  logic [15:0] MEAS_AUX1,
  input  logic [15:0] MEAS_AUX2,
  input  logic [15:0] MEAS_AUX3,
  input  logic [7:0]  ALM,
  input  logic        OT,
  input  logic        EOS,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic        FRAME_DROPPED,
  output logic [7:0]  SEQ_NUM
);

  localparam logic [7:0] DEC_LAST = 8'(DECIMATION - 1);
`ifdef XADC_TELEM_CHECKSUM_EN
  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(FRAME_LEN_CSUM - 1);
`else
  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(FRAME_LEN_BASE - 1);
`endif

  state_t                  state;
  state_t                  state_nxt;
  logic                    eos_q;
  logic                    eos_edge;
  logic [7:0]              dcnt;
  logic                    trigger;
  logic [BYTE_IDX_W-1:0]   byte_idx;
  snap_t                   snap;
  logic [7:0]              seq;
  logic                    accept;
  logic                    last_byte;
  logic                    capture;
  logic                    frame_done;
  logic [7:0]              tx_byte;

  assign eos_edge  = EOS && !eos_q;
  assign trigger   = eos_edge && (dcnt == DEC_LAST);
  assign TX_VALID  = (state == SEND);
  assign accept    = TX_VALID && TX_READY;
  assign last_byte = (byte_idx == LAST_IDX);
  assign SEQ_NUM   = seq;

  // EOS edge detector and decimation counter; a held-high EOS counts once
  always_ff @(posedge DCLK or negedge RESET) begin
    if (!RESET) begin
      eos_q <= 1'b0;
      dcnt  <= 8'h00;
    end else begin
      eos_q <= EOS;
      if (eos_edge) dcnt <= (dcnt == DEC_LAST) ? 8'h00 : dcnt + 8'd1;
    end
  end

  // FSM state register
  always_ff @(posedge DCLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: start on trigger when idle, finish on acceptance of the last byte
  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          capture   = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (accept && last_byte) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot, byte index, sequence number and drop pulse
  always_ff @(posedge DCLK or negedge RESET) begin
    if (!RESET) begin
      snap          <= '0;
      byte_idx      <= '0;
      seq           <= 8'h00;
      FRAME_DROPPED <= 1'b0;
    end else begin
      FRAME_DROPPED <= trigger && (state == SEND);
      if (capture) begin
        snap.words <= {MEAS_AUX3, MEAS_AUX2, MEAS_AUX1, MEAS_AUX0,
                       MEAS_VCCBRAM, MEAS_VCCAUX, MEAS_VCCINT, MEAS_TEMP};
        snap.alm   <= ALM;
        snap.ot    <= OT;
        byte_idx   <= '0;
      end else if (frame_done) begin
        byte_idx <= '0;
        seq      <= seq + 8'd1;
      end else if (accept) begin
        byte_idx <= byte_idx + BYTE_IDX_W'(1);
      end
    end
  end

`ifdef XADC_TELEM_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR of bytes 1..19, cleared when a new frame is captured
  always_ff @(posedge DCLK or negedge RESET) begin
    if (!RESET)                           csum <= 8'h00;
    else if (capture)                     csum <= 8'h00;
    else if (accept && byte_idx != '0)    csum <= csum ^ TX_DATA;
  end

  // Output byte mux with checksum as the trailing byte
  always_comb begin
    tx_byte = frame_byte(byte_idx, snap, seq, SYNC_MARK);
    if (last_byte) tx_byte = csum;
    TX_DATA = TX_VALID ? tx_byte : 8'h00;
  end
`else
  // Output byte mux; zero while idle
  always_comb begin
    tx_byte = frame_byte(byte_idx, snap, seq, SYNC_MARK);
    TX_DATA = TX_VALID ? tx_byte : 8'h00;
  end
`endif

endmodule

// File: tb/tb_xadc_telemetry_packer.sv
// Directed bench for xadc_telemetry_packer: frame content, stalls, drops, decimation, seq wrap, reset.
// Latency: n/a (testbench).
// Backpressure: drives TX_READY steady or toggling to exercise stalls.
module tb_xadc_telemetry_packer;
  import xadc_telem_pkg::*;

`ifdef XADC_TELEM_CHECKSUM_EN
  localparam int FLEN = FRAME_LEN_CSUM;
`else
  localparam int FLEN = FRAME_LEN_BASE;
`endif

  logic             DCLK = 1'b0;
  logic             RESET = 1'b0;
  logic [7:0][15:0] wv = '0;
  logic [7:0]       alm = 8'h00;
  logic             ot = 1'b0;
  logic             eos1 = 1'b0, eos4 = 1'b0;
  logic             rdy1 = 1'b1, rdy4 = 1'b1;
  logic [7:0]       tx_data1, tx_data4, seq1, seq4;
  logic             tx_valid1, tx_valid4, drop1, drop4;

  int tests = 0;
  int fails = 0;

  always #5 DCLK = ~DCLK;

  xadc_telemetry_packer #(.SYNC_MARK(8'hA5), .DECIMATION(1)) dut1 (
    .DCLK(DCLK), .RESET(RESET),
    .MEAS_TEMP(wv[0]), .MEAS_VCCINT(wv[1]), .MEAS_VCCAUX(wv[2]), .MEAS_VCCBRAM(wv[3]),
    .MEAS_AUX0(wv[4]), .MEAS_AUX1(wv[5]), .MEAS_AUX2(wv[6]), .MEAS_AUX3(wv[7]),
    .ALM(alm), .OT(ot), .EOS(eos1),
    .TX_DATA(tx_data1), .TX_VALID(tx_valid1), .TX_READY(rdy1),
    .FRAME_DROPPED(drop1), .SEQ_NUM(seq1)
  );

  xadc_telemetry_packer #(.SYNC_MARK(8'hA5), .DECIMATION(4)) dut4 (
    .DCLK(DCLK), .RESET(RESET),
    .MEAS_TEMP(wv[0]), .MEAS_VCCINT(wv[1]), .MEAS_VCCAUX(wv[2]), .MEAS_VCCBRAM(wv[3]),
    .MEAS_AUX0(wv[4]), .MEAS_AUX1(wv[5]), .MEAS_AUX2(wv[6]), .MEAS_AUX3(wv[7]),
    .ALM(alm), .OT(ot), .EOS(eos4),
    .TX_DATA(tx_data4), .TX_VALID(tx_valid4), .TX_READY(rdy4),
    .FRAME_DROPPED(drop4), .SEQ_NUM(seq4)
  );

  // Drop-pulse monitor on dut1
  int   drop_cnt = 0, drop_wide = 0;
  logic drop_prev = 1'b0;
  always @(negedge DCLK) begin
    if (drop1 && drop_prev) drop_wide++;
    if (drop1) drop_cnt++;
    drop_prev = drop1;
  end

  // Frame-start monitor on dut4: log SEQ_NUM at each TX_VALID rise
  int         fcnt4 = 0;
  logic [7:0] log4 [8];
  logic       vld4_prev = 1'b0;
  always @(negedge DCLK) begin
    if (tx_valid4 && !vld4_prev && fcnt4 < 8) begin
      log4[fcnt4] = seq4;
      fcnt4++;
    end
    vld4_prev = tx_valid4;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One EOS pulse on dut1, then collect and check a whole frame
  task automatic run_frame(input logic [7:0] seq, input int mode, input logic [7:0] csum, input bit inject);
    logic [7:0] exp [21];
    logic [7:0] held;
    logic [7:0] nxt;
    int         got, cyc;
    bit         stall;
    exp[0] = 8'hA5; exp[1] = seq; exp[2] = alm; exp[3] = {7'b0, ot};
    for (int i = 0; i < 8; i++) begin
      exp[4 + 2*i] = wv[i][15:8];
      exp[5 + 2*i] = wv[i][7:0];
    end
    exp[20] = csum;
    @(negedge DCLK); eos1 = 1'b1; rdy1 = 1'b1;
    @(negedge DCLK); eos1 = 1'b0;
    got = 0; cyc = 0; stall = 1'b0; held = 8'h00;
    while (got < FLEN && cyc < 400) begin
      if (inject && got == 8) eos1 = 1'b0;
      rdy1 = (mode == 1) ? ((cyc % 2) == 0) : 1'b1;
      if (stall) check("stall_hold", tx_data1, held);
      check("no_gap", tx_valid1, 1);
      if (tx_valid1 && rdy1) begin
        check($sformatf("seq%0h_byte%0d", seq, got), tx_data1, exp[got]);
        if (inject && got == 7) eos1 = 1'b1;
        got++;
        stall = 1'b0;
      end else begin
        stall = tx_valid1;
        held  = tx_data1;
      end
      @(negedge DCLK);
      cyc++;
    end
    eos1 = 1'b0;
    rdy1 = 1'b1;
    if (got < FLEN) check("frame_timeout", got, FLEN);
    nxt = seq + 8'd1;
    check("vld_after_frame", tx_valid1, 0);
    check("seq_num_after", seq1, nxt);
  endtask

  typedef struct {
    logic [7:0][15:0] words;
    logic [7:0]       alm;
    logic             ot;
    int               mode;
    logic [7:0]       seq;
    logic [7:0]       csum;
  } vec_t;

  vec_t             vt [4];
  logic [7:0][15:0] plan;
  int               d0, w0, cnt, got, cyc;

  initial begin
    plan = {16'h8899, 16'h7788, 16'h6677, 16'h5566, 16'h4455, 16'h3344, 16'h2233, 16'h1234};
    vt[0] = '{plan, 8'h05, 1'b1, 0, 8'h00, 8'h99};
    vt[1] = '{plan, 8'h05, 1'b1, 1, 8'h01, 8'h98};
    vt[2] = '{{8{16'hFFFF}}, 8'hFF, 1'b0, 0, 8'h02, 8'hFD};
    vt[3] = '{{16'h0008, 16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001},
              8'h80, 1'b1, 1, 8'h03, 8'h8A};

    // Reset state
    repeat (3) @(negedge DCLK);
    check("rst_valid", tx_valid1, 0);
    check("rst_data", tx_data1, 0);
    check("rst_drop", drop1, 0);
    check("rst_seq", seq1, 0);
    RESET = 1'b1;
    repeat (2) @(negedge DCLK);

    // Table-driven frames, steady and toggling TX_READY
    for (int v = 0; v < 4; v++) begin
      wv = vt[v].words; alm = vt[v].alm; ot = vt[v].ot;
      run_frame(vt[v].seq, vt[v].mode, vt[v].csum, 1'b0);
      repeat (3) @(negedge DCLK);
    end

    // EOS during byte 7: one drop pulse, frame unchanged, no follow-up frame
    wv = plan; alm = 8'h05; ot = 1'b1;
    d0 = drop_cnt; w0 = drop_wide;
    run_frame(8'h04, 0, 8'h9D, 1'b1);
    cnt = 0;
    repeat (40) begin
      @(negedge DCLK);
      if (tx_valid1) cnt++;
    end
    check("drop_pulses", drop_cnt - d0, 1);
    check("drop_width", drop_wide - w0, 0);
    check("no_second_frame", cnt, 0);

    // Sequence wrap: frames 5..255, then the 257th frame carries seq 00
    for (int s = 5; s < 256; s++) run_frame(8'(s), 0, 8'h99 ^ 8'(s), 1'b0);
    run_frame(8'h00, 0, 8'h99, 1'b0);

    // Reset asserted at byte 10 abandons the frame
    @(negedge DCLK); eos1 = 1'b1;
    @(negedge DCLK); eos1 = 1'b0;
    got = 0; cyc = 0;
    while (got < 10 && cyc < 50) begin
      if (tx_valid1) got++;
      @(negedge DCLK);
      cyc++;
    end
    check("pre_reset_bytes", got, 10);
    check("pre_reset_valid", tx_valid1, 1);
    RESET = 1'b0;
    #1;
    check("reset_valid", tx_valid1, 0);
    check("reset_data", tx_data1, 0);
    check("reset_seq", seq1, 0);
    repeat (2) @(negedge DCLK);
    RESET = 1'b1;
    repeat (2) @(negedge DCLK);
    check("post_reset_idle", tx_valid1, 0);

    // All-zero frame after reset (checksum 00), then TEMP=00FF after another reset (checksum FF)
    wv = '0; alm = 8'h00; ot = 1'b0;
    run_frame(8'h00, 0, 8'h00, 1'b0);
    RESET = 1'b0;
    repeat (2) @(negedge DCLK);
    RESET = 1'b1;
    @(negedge DCLK);
    wv[0] = 16'h00FF;
    run_frame(8'h00, 0, 8'hFF, 1'b0);

    // DECIMATION=4: 12 edges spaced 40 cycles -> 3 frames, seq 0,1,2
    wv = plan; alm = 8'h05; ot = 1'b1;
    repeat (12) begin
      @(negedge DCLK); eos4 = 1'b1;
      @(negedge DCLK); eos4 = 1'b0;
      repeat (38) @(negedge DCLK);
    end
    check("dec_frames", fcnt4, 3);
    check("dec_seq0", log4[0], 8'h00);
    check("dec_seq1", log4[1], 8'h01);
    check("dec_seq2", log4[2], 8'h02);
    check("dec_seq_num", seq4, 8'h03);
    check("dec_idle", tx_valid4, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
